// File: rtl/div_restoring_unit.sv
// Multi-cycle unsigned restoring divider: one borrow-chain trial subtraction per cycle,
// quotient to LO, remainder to HI, with a one-cycle done pulse and divide-by-zero flag.
module div_restoring_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int COUNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   r_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [COUNT_W-1:0] count_reg;

    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   trial_diff;
    logic [WIDTH:0]     borrow_chain;
    logic               borrow;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   q_next;

    assign r_shift         = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign borrow_chain[0] = 1'b0;

    // Ripple of full-subtractor cells; the zero-extended top bit of the trial equals the final borrow.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sub
            assign trial_diff[gi]     = r_shift[gi] ^ divisor_reg[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~r_shift[gi] & divisor_reg[gi])
                                      | (~(r_shift[gi] ^ divisor_reg[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign borrow = borrow_chain[WIDTH];
    assign r_next = borrow ? r_shift : trial_diff;
    assign q_next = {q_reg[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            divisor_reg <= '0;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            divisor_reg <= divisor;
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            count_reg   <= COUNT_W'(WIDTH);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state_reg   <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_reg     <= q_next;
                    r_reg     <= r_next;
                    count_reg <= count_reg - COUNT_W'(1);
                    // Publish results only on the final step so outputs hold during RUN.
                    if (count_reg == COUNT_W'(1)) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_restoring_unit.md
# div_restoring_unit

Multi-cycle unsigned restoring divider for the MIPS DIVU/DIV path. It sits downstream of the full-subtractor cell: each cycle it performs one WIDTH+1-bit trial subtraction and uses the borrow-out to pick the quotient bit. It then restores or keeps the partial remainder. Results go to the HI (remainder) and LO (quotient) registers; the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  request; sampled on a rising edge in IDLE or DONE only.
- `dividend`  input  WIDTH  unsigned numerator; sampled with `start`.
- `divisor`  input  WIDTH  unsigned denominator; sampled with `start`.
- `busy`  output  1  high in RUN state.
- `done`  output  1  one-cycle pulse, high in DONE state.
- `quotient`  output  WIDTH  LO result; held until next accepted `start`.
- `remainder`  output  WIDTH  HI result; held until next accepted `start`.
- `div_by_zero`  output  1  set with `done` when divisor was 0; held with the results.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; `busy`, `done` and `div_by_zero` are 0; `quotient` and `remainder` are 0; counter 0.
- IDLE or DONE with `start`=1 and divisor≠0:
  - Latch the divisor.
  - Load Q with the dividend and R with 0.
  - Set the counter to WIDTH and clear `div_by_zero`.
  - Go to RUN.
- IDLE or DONE with `start`=1 and divisor=0:
  - Set `quotient` to all ones, `remainder` to the dividend, and `div_by_zero` to 1.
  - Go to DONE.
- RUN, each edge:
  - Shift {R,Q} left by 1, giving R' = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - Compute the WIDTH+1-bit trial T = {1'b0,R'} − {1'b0,divisor}.
  - Borrow means T[WIDTH]=1 (same polarity as the subtractor's carry_out).
  - Borrow=1: R ← R', new Q LSB ← 0 (restore).
  - Borrow=0: R ← T[WIDTH-1:0], new Q LSB ← 1.
  - Decrement the counter. When the counter reaches 1 on this edge, go to DONE.
- DONE: `done`=1 for exactly one cycle. Without `start`, go to IDLE on the next edge.
- `start` in RUN is ignored. The operands are not re-sampled and the result is unaffected.
- `quotient`/`remainder` outputs mirror Q/R only after the final RUN edge. They keep their previous values during RUN.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values; no `done` pulse is issued.
- Arithmetic is unsigned only. Sign handling for DIV lives in the wrapper, not here.

## Timing
- Latency, normal divide: `start` sampled at edge E0. `busy` is high after E0 through edge E0+WIDTH. `done` is high for the cycle after E0+WIDTH, i.e. WIDTH+1 cycles from start to done (33 for WIDTH=32).
- Latency, divide-by-zero: `done` is high for the cycle after E0, i.e. 1 cycle.
- Results are valid in the same cycle `done` is high, and stable until the edge that accepts the next `start`.
- Back-to-back operation: a `start` in the DONE cycle is accepted on that edge. The next operation begins with no IDLE bubble.
- Reset is asynchronous. Outputs change without waiting for `clk`. Deassertion is assumed synchronous to `clk` by the system reset logic.

## Test plan
- 100 / 7, then wait: `busy`=1 for 32 cycles, `done` pulses 33 cycles after start, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 0xFFFFFFFF / 1 → `quotient`=0xFFFFFFFF, `remainder`=0. Then 3 / 10 → `quotient`=0, `remainder`=3, each with 33-cycle latency.
- 5 / 0 → `done` one cycle after start, `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1, `busy` never high.
- 100 / 7 started; at cycle 10 pulse `start` with 9 / 3 → ignored: result still 14 r 2 at cycle 33.
- 100 / 7 started; assert `reset` at cycle 10 → `busy`, `done`, `quotient`, `remainder` go to 0 immediately; no `done` after release.
- 100 / 7; in its `done` cycle, `start` with 0x80000000 / 0x10 → `done` again 33 cycles later with `quotient`=0x08000000, `remainder`=0.
